can_rx_buff: RTL and testbench
==============================

Name: can_rx_buff

Overview:
Receive-side frame buffer for the CAN controller, the counterpart of the transmit buffer.
- Accepts destuffed frame bytes from the bit-level receiver and checks byte count against RTR/DLC.
- Commits complete frames into a circular set of frame slots and presents the oldest frame to the host controller through a random-access byte-read port with release handshake.

Parameters:
SLOTS, 2, number of frame slots (legal 1..4); each slot holds 10 bytes.
PTR_W, 2, slot pointer width; must satisfy 2**PTR_W >= SLOTS.

Ports:
clk  in  1  clock
g_rst  in  1  reset, asynchronous, active-high
rx_sof  in  1  start-of-frame pulse from receiver
rx_byte_vld  in  1  rx_byte valid strobe
rx_byte  in  8  frame byte: byte0=ID[10:3]; byte1={ID[2:0],RTR,DLC[3:0]}; bytes2..9=data
rx_eof  in  1  end-of-frame pulse (CRC/ACK good)
rx_abort  in  1  frame error from receiver; discard current frame
host_rd_addr  in  4  byte index 0..9 within head slot
host_rel  in  1  pulse: release head slot
host_clr_ovr  in  1  pulse: clear rx_overrun
rx_frame_rdy  out  1  head slot holds a committed frame
host_rd_data  out  8  registered byte of head slot at host_rd_addr
rx_id  out  11  head-slot identifier
rx_rtr  out  1  head-slot RTR bit
rx_dlc  out  4  head-slot DLC
rx_frame_cnt  out  3  committed frames held (0..SLOTS)
rx_busy  out  1  write FSM not IDLE
rx_overrun  out  1  sticky: frame completed with no free slot
rx_err  out  1  one-cycle pulse: frame discarded (abort or length mismatch)

Behaviour:
- Reset: all outputs 0. Pointers, count and FSM cleared. Slot storage zeroed. Reset mid-frame discards the frame silently; no rx_err.
- Write FSM states:
  - IDLE: rx_sof -> HDR. Byte counter=0. Target = tail slot if count<SLOTS, else discard mode (bytes counted, not stored).
  - HDR: first two rx_byte_vld bytes are stored at index 0,1. After byte1, expected = 2 + (RTR ? 0 : min(DLC,8)). If expected==2 -> WAIT_EOF, else -> DATA.
  - DATA: store bytes at index 2.. until counter==expected, then -> WAIT_EOF. Extra bytes (counter would exceed 10) are not stored and set mismatch.
  - WAIT_EOF: further rx_byte_vld sets mismatch.
- rx_eof in any non-IDLE state:
  - Commit if state is WAIT_EOF, no mismatch, and not in discard mode: tail advances modulo SLOTS, count+1.
  - In discard mode, a length-valid frame sets rx_overrun and is not committed.
  - Otherwise discard and pulse rx_err next cycle.
  - In all cases -> IDLE.
- rx_eof in same cycle as rx_byte_vld: byte processed first, then eof evaluated with updated counter.
- rx_abort (any state except IDLE): discard, rx_err pulse, -> IDLE. rx_abort wins over coincident rx_eof.
- rx_sof while not IDLE: current frame discarded with rx_err pulse; new frame starts the same cycle into the same target slot.
- rx_eof/rx_abort in IDLE: ignored.
- Commit latency: rx_frame_rdy, rx_frame_cnt and header outputs update the cycle after the rx_eof cycle.
- rx_frame_rdy = (count != 0). rx_id, rx_rtr, rx_dlc are combinational from head slot bytes 0,1; 0 when empty.
- host_rd_data: registered, 1-cycle latency from host_rd_addr. Addr >9 or empty buffer returns 0.
- host_rel with rx_frame_rdy=1: head advances modulo SLOTS, count-1 next cycle. host_rel with rx_frame_rdy=0: ignored.
- Simultaneous commit and release: both happen, count unchanged. A slot freed by release in the same cycle as rx_sof is not usable by that frame (free check uses registered count).
- Writes never target the head slot while count>0 and count<SLOTS, since tail!=head.
- rx_overrun: set as above; cleared by host_clr_ovr; set wins over simultaneous clear.
- rx_busy = (state != IDLE).

Optional Feature:
CAN_RX_ACC_FILTER_EN
- Defined: adds inputs acc_code[10:0] and acc_mask[10:0]. After byte1, a frame is accepted iff ((ID ^ acc_code) & acc_mask)==0. Rejected frames are counted to completion but never committed. A rejected frame raises no rx_overrun; rx_err still pulses on abort or length mismatch.
- Undefined: ports absent; all frames accepted.

Test Plan:
- Reset, then SOF, bytes 0x24,0x62,0x11,0x22 (ID=0x123, RTR=0, DLC=2), EOF -> next cycle rx_frame_rdy=1, rx_id=0x123, rx_dlc=2, rx_frame_cnt=1. Read addr 3 -> host_rd_data=0x22 one cycle later.
- RTR frame: bytes 0x24,0x74 (RTR=1, DLC=4), EOF -> committed, rx_rtr=1. Reading addr 2 returns 0x00.
- Length error: header DLC=3, only 2 data bytes, EOF -> rx_err one pulse, rx_frame_cnt unchanged. Same result for rx_abort mid-DATA.
- Overrun (SLOTS=2): commit two frames without release, send a third valid frame -> rx_overrun=1, cnt=2, head still first frame. host_clr_ovr -> rx_overrun=0.
- host_rel on the same cycle as a commit with cnt=1 -> cnt stays 1, head shows the second frame. host_rel at cnt=0 -> no change.
- g_rst asserted mid-DATA -> all outputs 0 immediately. A following clean frame commits normally into slot 0.

Source files
------------

// File: rtl/can_rx_buff.sv
// CAN receive frame buffer: length-checked byte capture into circular slots.
// Optional acceptance filter enabled by defining CAN_RX_ACC_FILTER_EN.
module can_rx_buff #(
  parameter int SLOTS = 2,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        g_rst,
  input  logic        rx_sof,
  input  logic        rx_byte_vld,
  input  logic [7:0]  rx_byte,
  input  logic        rx_eof,
  input  logic        rx_abort,
  input  logic [3:0]  host_rd_addr,
  input  logic        host_rel,
  input  logic        host_clr_ovr,
`ifdef CAN_RX_ACC_FILTER_EN
  input  logic [10:0] acc_code,
  input  logic [10:0] acc_mask,
`endif
  output logic        rx_frame_rdy,
  output logic [7:0]  host_rd_data,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [2:0]  rx_frame_cnt,
  output logic        rx_busy,
  output logic        rx_overrun,
  output logic        rx_err
);

  localparam int NS = 1 << PTR_W;
  localparam logic [2:0] SLOTS_C = 3'(SLOTS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT_EOF} state_t;

  state_t state_q, state_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [3:0] exp_q, exp_d;
  logic mis_q, mis_d;
  logic disc_q, disc_d;
  logic err_q, err_d;
  logic ovr_q, ovr_d;
  logic [2:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [7:0] rd_q, rd_d;
  logic [15:0][7:0] mem_q [NS];
  logic [15:0][7:0] mem_d [NS];

  logic commit, rel, ovr_set, len_ok, acc_ok;
  logic [3:0] dlc_c;
  logic [7:0] hb0, hb1;

`ifdef CAN_RX_ACC_FILTER_EN
  logic [7:0] b0_q, b0_d;
  logic rej_q, rej_d;
  logic [10:0] id_c;
  assign id_c = {b0_q, rx_byte[7:5]};
`endif

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign dlc_c = (rx_byte[3:0] > 4'd8) ? 4'd8 : rx_byte[3:0];
  assign rel = host_rel && (count_q != 3'd0);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    exp_d   = exp_q;
    mis_d   = mis_q;
    disc_d  = disc_q;
    mem_d   = mem_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    ovr_set = 1'b0;
    len_ok  = 1'b0;
`ifdef CAN_RX_ACC_FILTER_EN
    b0_d   = b0_q;
    rej_d  = rej_q;
`endif
    if (rx_sof) begin
      // A frame cut short by a new SOF is an error, but the new one proceeds.
      err_d   = (state_q != IDLE);
      state_d = HDR;
      bcnt_d  = 4'd0;
      exp_d   = 4'd0;
      mis_d   = 1'b0;
      disc_d  = (count_q >= SLOTS_C);
`ifdef CAN_RX_ACC_FILTER_EN
      rej_d   = 1'b0;
`endif
    end else if (state_q != IDLE) begin
      if (rx_abort) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        if (rx_byte_vld) begin
          unique case (state_q)
            HDR: begin
              if (!disc_q) mem_d[tail_q][bcnt_q] = rx_byte;
              bcnt_d = bcnt_q + 4'd1;
              if (bcnt_q == 4'd1) begin
                exp_d = rx_byte[4] ? 4'd2 : 4'd2 + dlc_c;
                state_d = (exp_d == 4'd2) ? WAIT_EOF : DATA;
`ifdef CAN_RX_ACC_FILTER_EN
                rej_d = |((id_c ^ acc_code) & acc_mask);
              end else begin
                b0_d = rx_byte;
`endif
              end
            end
            DATA: begin
              if (bcnt_q < 4'd10) begin
                if (!disc_q) mem_d[tail_q][bcnt_q] = rx_byte;
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_d == exp_q) state_d = WAIT_EOF;
              end else begin
                mis_d = 1'b1;
              end
            end
            WAIT_EOF: mis_d = 1'b1;
            default: ;
          endcase
        end
        if (rx_eof) begin
          len_ok  = (state_d == WAIT_EOF) && !mis_d;
          state_d = IDLE;
          if (!len_ok)     err_d   = 1'b1;
          else if (!acc_ok) ;
          else if (disc_q) ovr_set = 1'b1;
          else             commit  = 1'b1;
        end
      end
    end
  end

`ifdef CAN_RX_ACC_FILTER_EN
  assign acc_ok = !rej_d;
`else
  assign acc_ok = 1'b1;
`endif

  always_comb begin
    count_d = count_q + {2'b0, commit} - {2'b0, rel};
    tail_d  = commit ? inc(tail_q) : tail_q;
    head_d  = rel ? inc(head_q) : head_q;
    ovr_d   = ovr_set | (ovr_q & ~host_clr_ovr);
    rd_d    = 8'h00;
    if (count_q != 3'd0 && host_rd_addr < 4'd10)
      rd_d = mem_q[head_q][host_rd_addr];
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      disc_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      rd_q    <= '0;
      mem_q   <= '{default: '0};
`ifdef CAN_RX_ACC_FILTER_EN
      b0_q    <= '0;
      rej_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
      disc_q  <= disc_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
`ifdef CAN_RX_ACC_FILTER_EN
      b0_q    <= b0_d;
      rej_q   <= rej_d;
`endif
    end
  end

  assign hb0 = mem_q[head_q][0];
  assign hb1 = mem_q[head_q][1];

  assign rx_frame_rdy = (count_q != 3'd0);
  assign rx_id        = rx_frame_rdy ? {hb0, hb1[7:5]} : 11'd0;
  assign rx_rtr       = rx_frame_rdy & hb1[4];
  assign rx_dlc       = rx_frame_rdy ? hb1[3:0] : 4'd0;
  assign rx_frame_cnt = count_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_overrun   = ovr_q;
  assign rx_err       = err_q;
  assign host_rd_data = rd_q;

endmodule

// File: tb/tb_can_rx_buff.sv
// Directed self-checking bench for can_rx_buff (default build, SLOTS=2).
module tb_can_rx_buff;

  logic clk = 1'b0;
  logic g_rst, rx_sof, rx_byte_vld, rx_eof, rx_abort;
  logic [7:0] rx_byte;
  logic [3:0] host_rd_addr;
  logic host_rel, host_clr_ovr;
  logic rx_frame_rdy, rx_rtr, rx_busy, rx_overrun, rx_err;
  logic [7:0] host_rd_data;
  logic [10:0] rx_id;
  logic [3:0] rx_dlc;
  logic [2:0] rx_frame_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  can_rx_buff #(.SLOTS(2), .PTR_W(2)) dut (
    .clk(clk), .g_rst(g_rst), .rx_sof(rx_sof),
    .rx_byte_vld(rx_byte_vld), .rx_byte(rx_byte),
    .rx_eof(rx_eof), .rx_abort(rx_abort),
    .host_rd_addr(host_rd_addr), .host_rel(host_rel),
    .host_clr_ovr(host_clr_ovr),
    .rx_frame_rdy(rx_frame_rdy), .host_rd_data(host_rd_data),
    .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
    .rx_frame_cnt(rx_frame_cnt), .rx_busy(rx_busy),
    .rx_overrun(rx_overrun), .rx_err(rx_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    rx_sof = 1'b1;
    tick();
    rx_sof = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_byte_vld = 1'b1;
      rx_byte = b[i];
      tick();
    end
    rx_byte_vld = 1'b0;
  endtask

  task automatic end_eof();
    rx_eof = 1'b1;
    tick();
    rx_eof = 1'b0;
  endtask

  task automatic release_head();
    host_rel = 1'b1;
    tick();
    host_rel = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({rx_frame_rdy, rx_frame_cnt, rx_busy, rx_overrun, rx_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0",
               {rx_frame_rdy, rx_frame_cnt, rx_busy, rx_overrun, rx_err});
    end
    checks++;
    if ({rx_id, rx_rtr, rx_dlc, host_rd_data} !== 24'd0) begin
      errors++;
      $display("FAIL reset_hdr got id=%h rd=%h want 0", rx_id, host_rd_data);
    end
    tick();
    g_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    rx_sof = 1'b1;
    tick();
    rx_sof = 1'b0;
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b want 1", rx_busy);
    end
    for (int i = 0; i < 4; i++) begin
      rx_byte_vld = 1'b1;
      rx_byte = (i == 0) ? 8'h24 : (i == 1) ? 8'h62 : (i == 2) ? 8'h11 : 8'h22;
      tick();
    end
    rx_byte_vld = 1'b0;
    checks++;
    if (rx_frame_cnt !== 3'd0) begin
      errors++; $display("FAIL basic_precommit cnt got %0d want 0", rx_frame_cnt);
    end
    end_eof();
    checks++;
    if ({rx_frame_rdy, rx_id, rx_rtr, rx_dlc, rx_frame_cnt} !== {1'b1, 11'h123, 1'b0, 4'd2, 3'd1}) begin
      errors++;
      $display("FAIL basic_commit got rdy=%b id=%h rtr=%b dlc=%0d cnt=%0d want 1/123/0/2/1",
               rx_frame_rdy, rx_id, rx_rtr, rx_dlc, rx_frame_cnt);
    end
    host_rd_addr = 4'd3;
    tick();
    checks++;
    if (host_rd_data !== 8'h22) begin
      errors++; $display("FAIL basic_read3 got %h want 22", host_rd_data);
    end
    release_head();
    checks++;
    if (rx_frame_cnt !== 3'd0 || rx_frame_rdy !== 1'b0) begin
      errors++; $display("FAIL basic_release cnt got %0d want 0", rx_frame_cnt);
    end
  endtask

  task automatic test_rtr();
    start_frame(2, 8'h24, 8'h74, 8'h00, 8'h00);
    end_eof();
    checks++;
    if ({rx_frame_cnt, rx_rtr, rx_dlc, rx_id} !== {3'd1, 1'b1, 4'd4, 11'h123}) begin
      errors++;
      $display("FAIL rtr_commit got cnt=%0d rtr=%b dlc=%0d id=%h want 1/1/4/123",
               rx_frame_cnt, rx_rtr, rx_dlc, rx_id);
    end
    host_rd_addr = 4'd2;
    tick();
    checks++;
    if (host_rd_data !== 8'h00) begin
      errors++; $display("FAIL rtr_read2 got %h want 00", host_rd_data);
    end
    host_rd_addr = 4'd1;
    tick();
    checks++;
    if (host_rd_data !== 8'h74) begin
      errors++; $display("FAIL rtr_read1 got %h want 74", host_rd_data);
    end
    host_rd_addr = 4'd12;
    tick();
    checks++;
    if (host_rd_data !== 8'h00) begin
      errors++; $display("FAIL rtr_read12 got %h want 00", host_rd_data);
    end
    release_head();
  endtask

  task automatic test_len_err();
    start_frame(4, 8'h24, 8'h63, 8'hAA, 8'hBB);
    end_eof();
    checks++;
    if (rx_err !== 1'b1 || rx_frame_cnt !== 3'd0) begin
      errors++; $display("FAIL len_err got err=%b cnt=%0d want 1/0", rx_err, rx_frame_cnt);
    end
    tick();
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL len_err_pulse got %b want 0", rx_err);
    end
    start_frame(3, 8'h24, 8'h63, 8'hAA, 8'h00);
    rx_abort = 1'b1;
    rx_eof = 1'b1;
    tick();
    rx_abort = 1'b0;
    rx_eof = 1'b0;
    checks++;
    if ({rx_err, rx_frame_cnt, rx_busy} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort got err=%b cnt=%0d busy=%b want 1/0/0",
               rx_err, rx_frame_cnt, rx_busy);
    end
    tick();
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL abort_pulse got %b want 0", rx_err);
    end
  endtask

  task automatic test_overrun();
    start_frame(4, 8'h24, 8'h62, 8'h11, 8'h22);
    end_eof();
    start_frame(3, 8'h48, 8'h41, 8'h55, 8'h00);
    end_eof();
    checks++;
    if (rx_frame_cnt !== 3'd2 || rx_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_fill got cnt=%0d ovr=%b want 2/0", rx_frame_cnt, rx_overrun);
    end
    start_frame(2, 8'h24, 8'h60, 8'h00, 8'h00);
    end_eof();
    checks++;
    if ({rx_overrun, rx_frame_cnt, rx_id, rx_err} !== {1'b1, 3'd2, 11'h123, 1'b0}) begin
      errors++;
      $display("FAIL ovr_set got ovr=%b cnt=%0d id=%h err=%b want 1/2/123/0",
               rx_overrun, rx_frame_cnt, rx_id, rx_err);
    end
    host_clr_ovr = 1'b1;
    tick();
    host_clr_ovr = 1'b0;
    checks++;
    if (rx_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear got %b want 0", rx_overrun);
    end
  endtask

  task automatic test_rel_commit();
    release_head();
    checks++;
    if (rx_frame_cnt !== 3'd1 || rx_id !== 11'h242 || rx_dlc !== 4'd1) begin
      errors++;
      $display("FAIL rel_head got cnt=%0d id=%h dlc=%0d want 1/242/1",
               rx_frame_cnt, rx_id, rx_dlc);
    end
    start_frame(2, 8'h24, 8'h60, 8'h00, 8'h00);
    host_rel = 1'b1;
    end_eof();
    host_rel = 1'b0;
    checks++;
    if ({rx_frame_cnt, rx_id, rx_dlc} !== {3'd1, 11'h123, 4'd0}) begin
      errors++;
      $display("FAIL rel_commit got cnt=%0d id=%h dlc=%0d want 1/123/0",
               rx_frame_cnt, rx_id, rx_dlc);
    end
    release_head();
    release_head();
    checks++;
    if (rx_frame_cnt !== 3'd0 || rx_frame_rdy !== 1'b0 || rx_id !== 11'd0) begin
      errors++;
      $display("FAIL rel_empty got cnt=%0d rdy=%b id=%h want 0/0/0",
               rx_frame_cnt, rx_frame_rdy, rx_id);
    end
  endtask

  task automatic test_reset_mid();
    start_frame(3, 8'h24, 8'h62, 8'h11, 8'h00);
    #2;
    g_rst = 1'b1;
    #1;
    checks++;
    if ({rx_busy, rx_frame_cnt, rx_frame_rdy, rx_err, rx_overrun} !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b cnt=%0d rdy=%b err=%b want 0",
               rx_busy, rx_frame_cnt, rx_frame_rdy, rx_err);
    end
    tick();
    g_rst = 1'b0;
    tick();
    checks++;
    if (rx_err !== 1'b0) begin
      errors++; $display("FAIL rst_no_err got %b want 0", rx_err);
    end
    start_frame(3, 8'h48, 8'h41, 8'h55, 8'h00);
    end_eof();
    host_rd_addr = 4'd2;
    tick();
    checks++;
    if ({rx_frame_cnt, rx_id, host_rd_data, rx_err} !== {3'd1, 11'h242, 8'h55, 1'b0}) begin
      errors++;
      $display("FAIL rst_recommit got cnt=%0d id=%h rd=%h err=%b want 1/242/55/0",
               rx_frame_cnt, rx_id, host_rd_data, rx_err);
    end
  endtask

  initial begin
    g_rst = 1'b1;
    rx_sof = 1'b0; rx_byte_vld = 1'b0; rx_byte = 8'h00;
    rx_eof = 1'b0; rx_abort = 1'b0;
    host_rd_addr = 4'd0; host_rel = 1'b0; host_clr_ovr = 1'b0;
    test_reset();
    test_basic();
    test_rtr();
    test_len_err();
    test_overrun();
    test_rel_commit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
